// File: rtl/niossystem_led_pwm.sv
// niossystem_led_pwm
//   Sits between the LED PIO and the LED pins. It applies global PWM dimming
//   and per-LED blinking, configured through a 4-word, zero-wait-state
//   Avalon-MM slave. While disabled, led_in passes through one register stage.
//
// Ports
//   clk        in   1   system clock (single domain)
//   reset_n    in   1   asynchronous active-low reset
//   led_in     in   8   LED value from the PIO out_port
//   address    in   2   register select (0 CTRL, 1 DUTY, 2 PRESCALE, 3 BLINK)
//   chipselect in   1   slave select
//   write_n    in   1   active-low write strobe
//   writedata  in  32   write data
//   readdata   out 32   combinational read data, unused bits zero
//   led_out    out  8   registered LED pin drive, reset value 0
//
// Bus handshake: a write happens on every clock edge where chipselect is
// high and write_n is low; there is no wait-request, so the slave always
// accepts. Reads have no side effects and readdata is valid in the same
// cycle that address is presented.
module niossystem_led_pwm #(
  parameter logic [15:0] PRESCALE_RESET = 16'd49
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  led_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led_out
);

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_DUTY     = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_BLINK    = 2'd3;

  // Configuration registers
  logic        r_enable;
  logic [7:0]  r_duty;
  logic [15:0] r_prescale;
  logic [7:0]  r_blink_mask;
  logic [7:0]  r_blink_half;

  // Counters and blink state
  logic [15:0] r_pre_cnt;
  logic [7:0]  r_pwm_cnt;
  logic [7:0]  r_blink_cnt;
  logic        r_blink_phase;
  logic [7:0]  r_led_out;

  logic w_wr;
  logic w_wr_ctrl_off;
  logic w_wr_prescale;
  logic w_wr_blink;
  logic w_tick;
  logic w_frame_end;
  logic w_pwm_on;
  logic [7:0] w_blink_off;

  assign w_wr          = chipselect && !write_n;
  assign w_wr_ctrl_off = w_wr && (address == ADDR_CTRL) && !writedata[0];
  assign w_wr_prescale = w_wr && (address == ADDR_PRESCALE);
  assign w_wr_blink    = w_wr && (address == ADDR_BLINK);

  assign w_tick      = r_enable && (r_pre_cnt == r_prescale);
  assign w_frame_end = w_tick && (r_pwm_cnt == 8'hFF);
  // Full-scale duty is special-cased so that 8'hFF really means always on.
  assign w_pwm_on    = (r_duty == 8'hFF) || (r_pwm_cnt < r_duty);
  assign w_blink_off = r_blink_mask & {8{r_blink_phase}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable     <= 1'b0;
      r_duty       <= 8'hFF;
      r_prescale   <= PRESCALE_RESET;
      r_blink_mask <= 8'h00;
      r_blink_half <= 8'h00;
    end else if (w_wr) begin
      case (address)
        ADDR_CTRL:     r_enable <= writedata[0];
        ADDR_DUTY:     r_duty <= writedata[7:0];
        ADDR_PRESCALE: r_prescale <= writedata[15:0];
        default: begin
          r_blink_mask <= writedata[7:0];
          r_blink_half <= writedata[15:8];
        end
      endcase
    end
  end

  // Register writes that restart a counter take priority over the count
  // and over any tick falling on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= 16'd0;
      r_pwm_cnt <= 8'd0;
    end else if (!r_enable || w_wr_ctrl_off || w_wr_prescale) begin
      r_pre_cnt <= 16'd0;
      r_pwm_cnt <= 8'd0;
    end else if (w_tick) begin
      r_pre_cnt <= 16'd0;
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end else begin
      r_pre_cnt <= r_pre_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= 8'd0;
      r_blink_phase <= 1'b0;
    end else if (!r_enable || w_wr_ctrl_off || w_wr_blink) begin
      r_blink_cnt   <= 8'd0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_blink_cnt == r_blink_half) begin
        r_blink_cnt   <= 8'd0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led_out <= 8'h00;
    end else if (r_enable) begin
      r_led_out <= led_in & {8{w_pwm_on}} & ~w_blink_off;
    end else begin
      r_led_out <= led_in;
    end
  end

  assign led_out = r_led_out;

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:     readdata = {31'd0, r_enable};
      ADDR_DUTY:     readdata = {24'd0, r_duty};
      ADDR_PRESCALE: readdata = {16'd0, r_prescale};
      default:       readdata = {15'd0, r_blink_phase, r_blink_half, r_blink_mask};
    endcase
  end

endmodule

// File: tb/tb_niossystem_led_pwm.sv
// Testbench for niossystem_led_pwm. The reference model tracks elapsed
// enabled cycles and completed frames and derives the PWM position and blink
// phase arithmetically from them; a monitor on the falling edge pops the
// expected led_out / readdata values and compares.
module tb_niossystem_led_pwm;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  led_in = 8'h00;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  led_out;

  always #5 clk = ~clk;

  niossystem_led_pwm dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .led_in     (led_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [31:0] rd_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_enable;
  logic [7:0]  m_duty;
  logic [15:0] m_prescale;
  logic [7:0]  m_mask;
  logic [7:0]  m_half;
  int          m_n;      // enabled cycles since the PWM timebase last restarted
  int          m_frames; // frames completed since the blink timebase restarted
  int          m_pwm;
  bit          m_on;
  bit          m_tick;
  logic [7:0]  m_exp;

  function automatic bit m_phase();
    return ((m_frames / (int'(m_half) + 1)) % 2) == 1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {31'd0, m_enable};
      2'd1:    return {24'd0, m_duty};
      2'd2:    return {16'd0, m_prescale};
      default: return {15'd0, m_phase(), m_half, m_mask};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_enable = 1'b0; m_duty = 8'hFF; m_prescale = 16'd49;
      m_mask = 8'h00; m_half = 8'h00; m_n = 0; m_frames = 0;
    end else begin
      m_pwm = (m_n / (int'(m_prescale) + 1)) % 256;
      m_on  = (m_duty == 8'hFF) || (m_pwm < int'(m_duty));
      if (m_enable)
        m_exp = led_in & (m_on ? 8'hFF : 8'h00) & ~(m_phase() ? m_mask : 8'h00);
      else
        m_exp = led_in;
      exp_q.push_back(m_exp);
      m_tick = m_enable && ((m_n % (int'(m_prescale) + 1)) == int'(m_prescale));
      if (m_enable) begin
        m_n++;
        if (m_tick && m_pwm == 255) m_frames++;
      end else begin
        m_n = 0;
        m_frames = 0;
      end
      if (chipselect && !write_n) begin
        case (address)
          2'd0: begin
            if (!writedata[0]) begin m_n = 0; m_frames = 0; end
            m_enable = writedata[0];
          end
          2'd1: m_duty = writedata[7:0];
          2'd2: begin m_prescale = writedata[15:0]; m_n = 0; end
          default: begin
            m_mask = writedata[7:0];
            m_half = writedata[15:8];
            m_frames = 0;
          end
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  logic [7:0]  mon_led;
  logic [31:0] mon_rd;
  always @(negedge clk) begin
    if (reset_n) begin
      if (exp_q.size() > 0) begin
        mon_led = exp_q.pop_front();
        check32("led_out", {24'd0, led_out}, {24'd0, mon_led});
      end
      if (rd_q.size() > 0) begin
        mon_rd = rd_q.pop_front();
        check32("readdata", readdata, mon_rd);
      end
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    rd_q.push_back(exp_rd(a));
    step(1);
    chipselect = 1'b0;
  endtask

  task automatic wait_tick_then_write_prescale(input logic [15:0] p);
    int guard;
    guard = 0;
    while (!(m_enable && ((m_n % (int'(m_prescale) + 1)) == int'(m_prescale))) && guard < 100) begin
      step(1);
      guard++;
    end
    n_checks++;
    if (guard >= 100) begin
      n_errors++;
      $display("FAIL tick_wait: got no tick within %0d cycles, required one", guard);
    end
    wr(2'd2, {16'd0, p});
  endtask

  // watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ones;
    int guard;
    int sel;
    logic [31:0] d;

    step(3);
    check32("reset_led_out", {24'd0, led_out}, 32'd0);
    reset_n = 1'b1;
    step(1);

    // reset values
    for (int a = 0; a < 4; a++) rd(2'(a));

    // passthrough while disabled
    led_in = 8'hA5;
    step(3);

    // duty 64 at prescale 0: exactly 64 of every 256 cycles on
    wr(2'd2, 32'd0);
    wr(2'd1, 32'd64);
    led_in = 8'hFF;
    wr(2'd0, 32'd1);
    step(300);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      if (led_out == 8'hFF) ones++;
    end
    check32("duty64_on_cycles", 32'(ones), 32'd64);

    // duty extremes with changing led_in
    wr(2'd1, 32'd0);
    for (int i = 0; i < 300; i++) begin led_in = 8'($urandom); step(1); end
    wr(2'd1, 32'hFF);
    for (int i = 0; i < 100; i++) begin led_in = 8'($urandom); step(1); end

    // blink: prescale 3, mask 0x0F, half 1 (bit 16 write is ignored)
    wr(2'd0, 32'd0);
    wr(2'd2, 32'd3);
    led_in = 8'hFF;
    wr(2'd3, 32'h0001_010F);
    wr(2'd0, 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(511);
      rd(2'd3);
    end

    // PRESCALE writes landing exactly on a tick
    wr(2'd1, 32'd100);
    wait_tick_then_write_prescale(16'd2);
    step(900);
    wait_tick_then_write_prescale(16'd1);
    step(700);
    rd(2'd2);

    // reset in the middle of the dimmed blink phase
    wr(2'd1, 32'hFF);
    wr(2'd2, 32'd0);
    wr(2'd3, 32'h0000_000F);
    led_in = 8'hFF;
    guard = 0;
    while (!m_phase() && guard < 600) begin step(1); guard++; end
    step(3);
    check32("pre_reset_led_out", {24'd0, led_out}, 32'h0000_00F0);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    rd_q.delete();
    #1;
    check32("async_reset_led_out", {24'd0, led_out}, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    for (int a = 0; a < 4; a++) rd(2'(a));
    for (int i = 0; i < 20; i++) begin led_in = 8'($urandom); step(1); end

    // randomized register traffic
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd1);
    for (int i = 0; i < 4000; i++) begin
      led_in = 8'($urandom);
      sel = int'($urandom_range(0, 39));
      if (sel < 4) begin
        case (sel)
          0: d = {31'd0, 1'($urandom_range(0, 3) != 0)};
          1: d = {24'd0, 8'($urandom)};
          2: d = 32'($urandom_range(0, 3));
          default: d = {15'd0, 1'($urandom), 8'($urandom_range(0, 2)), 8'($urandom)};
        endcase
        wr(2'(sel), d);
      end else if (sel < 7) begin
        rd(2'($urandom_range(0, 3)));
      end else begin
        step(1);
      end
    end

    step(3);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
